// File: rtl/mult_seq_if.sv
// Operand handshake, serial link to the downstream bit-serial multiplier,
// and the captured-result outputs of mult_seq.
interface mult_seq_if #(
    parameter int WIDTH = 8
);
    localparam int PW = 2 * WIDTH;

    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             o_q;
    logic             o_m;
    logic             o_clr_n;
    logic [PW-1:0]    i_prd;
    logic [PW-1:0]    o_prd;
    logic             o_done;

    modport master (
        output i_valid,
        output i_a,
        output i_b,
        output i_prd,
        input  o_ready,
        input  o_q,
        input  o_m,
        input  o_clr_n,
        input  o_prd,
        input  o_done
    );

    modport slave (
        input  i_valid,
        input  i_a,
        input  i_b,
        input  i_prd,
        output o_ready,
        output o_q,
        output o_m,
        output o_clr_n,
        output o_prd,
        output o_done
    );
endinterface

// File: rtl/mult_seq.sv
// Sequencer for a bit-serial multiplier: streams A<<j LSB first for each
// multiplier bit B[j], then captures the downstream product register.
module mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic      i_clk,
    input  logic      i_nrst,
    mult_seq_if.slave bus
);
    localparam int PW = 2 * WIDTH;
    localparam int JW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int KW = $clog2(PW);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [JW-1:0] J_LAST = JW'(WIDTH - 1);
    localparam logic [KW-1:0] K_LAST = KW'(PW - 1);
    localparam logic [KW-1:0] K_WID  = KW'(WIDTH);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [JW-1:0]    j_q, j_d;
    logic [KW-1:0]    k_q, k_d;
    logic             clr_n_q, clr_n_d;
    logic             done_q, done_d;
    logic [PW-1:0]    prd_q, prd_d;

    logic             run;
    logic [KW-1:0]    j_ext;
    logic [KW-1:0]    diff;
    logic             in_win;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        j_d     = j_q;
        k_d     = k_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.i_valid) begin
                    a_d     = bus.i_a;
                    b_d     = bus.i_b;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                j_d     = '0;
                k_d     = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (k_q == K_LAST) begin
                    k_d = '0;
                    if (j_q == J_LAST) begin
                        j_d     = '0;
                        state_d = S_DONE;
                    end else begin
                        j_d = j_q + JW'(1);
                    end
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Clear is registered so the downstream sees a glitch-free low cycle.
    always_comb begin
        clr_n_d = (state_d != S_CLEAR);
        done_d  = (state_q == S_DONE);
        prd_d   = (state_q == S_DONE) ? bus.i_prd : prd_q;
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            clr_n_q <= 1'b0;
            done_q  <= 1'b0;
            prd_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            j_q     <= j_d;
            k_q     <= k_d;
            clr_n_q <= clr_n_d;
            done_q  <= done_d;
            prd_q   <= prd_d;
        end
    end

    // Window j <= k < j+WIDTH selects A[k-j]; outside it A<<j is zero.
    always_comb begin
        run    = (state_q == S_RUN);
        j_ext  = KW'(j_q);
        diff   = k_q - j_ext;
        in_win = (k_q >= j_ext) && (diff < K_WID);
    end

    assign bus.o_ready = (state_q == S_IDLE);
    assign bus.o_q     = run & b_q[j_q];
    assign bus.o_m     = run & in_win & a_q[diff[JW-1:0]];
    assign bus.o_clr_n = clr_n_q;
    assign bus.o_done  = done_q;
    assign bus.o_prd   = prd_q;
endmodule

// File: doc/mult_seq.md
MULT_SEQ -- requirements
Module: mult_seq

Interface
REQ-001: Parameter WIDTH, default 8, SHALL set the operand width; the product width PW SHALL be 2*WIDTH (16 by default).
REQ-002: i_clk  input  1  SHALL be the single clock; all flops SHALL be rising-edge.
REQ-003: i_nrst  input  1  SHALL be the asynchronous, active-low reset.
REQ-004: i_valid  input  1  SHALL mean the operand pair is offered.
REQ-005: o_ready  output  1  SHALL mean the sequencer accepts operands; a transfer occurs on an edge with i_valid=1 and o_ready=1.
REQ-006: i_a  input  WIDTH  SHALL carry the multiplicand.
REQ-007: i_b  input  WIDTH  SHALL carry the multiplier.
REQ-008: o_q  output  1  SHALL carry the serial multiplier bit to the downstream serial multiplier.
REQ-009: o_m  output  1  SHALL carry the serial multiplicand bit, LSB first, to the downstream serial multiplier.
REQ-010: o_clr_n  output  1  SHALL be the active-low clear for the downstream multiplier, driven directly from a flop.
REQ-011: i_prd  input  PW  SHALL carry the product register of the downstream multiplier.
REQ-012: o_prd  output  PW  SHALL carry the captured result.
REQ-013: o_done  output  1  SHALL be a one-cycle pulse marking a new o_prd.

Function
REQ-014: The FSM SHALL have states IDLE, CLEAR, RUN and DONE.
REQ-015: IDLE SHALL drive o_ready=1; on a transfer, i_a and i_b SHALL be latched into A and B, and the next state SHALL be CLEAR.
REQ-016: o_ready SHALL be 0 in CLEAR, RUN and DONE; i_valid there SHALL be ignored and the operand registers SHALL NOT change.
REQ-017: CLEAR SHALL last exactly 1 cycle, with o_clr_n=0 for that cycle only; it SHALL zero counters j (pass, 0..WIDTH-1) and k (bit, 0..PW-1); the next state SHALL be RUN.
REQ-018: RUN SHALL last WIDTH*PW cycles (128 by default), with k incrementing every cycle.
REQ-019: When k=PW-1, k SHALL wrap to 0 and j SHALL increment.
REQ-020: RUN SHALL exit to DONE after the cycle with j=WIDTH-1 and k=PW-1.
REQ-021: In RUN, o_q SHALL be B[j]; o_m SHALL be A[k-j] when j<=k<j+WIDTH, else 0.
REQ-022: Each RUN pass SHALL therefore present A<<j as a zero-extended PW-bit LSB-first word.
REQ-023: Outside RUN, o_q and o_m SHALL be 0.
REQ-024: o_q and o_m MAY be combinational decodes of registered state and SHALL be stable before each rising edge.
REQ-025: DONE SHALL last 1 cycle; at its ending edge, o_prd SHALL load i_prd, o_done SHALL go to 1, and the state SHALL return to IDLE.
REQ-026: o_done SHALL be 1 for exactly one cycle and 0 otherwise.
REQ-027: o_prd SHALL hold its value until the next DONE.
REQ-028: Latency: with a transfer at edge E0, o_done SHALL rise at E0+WIDTH*PW+2 (E0+130 by default).
REQ-029: o_ready SHALL be 1 in the same cycle as o_done, so back-to-back throughput is one job per 130 cycles.
REQ-030: Arithmetic SHALL be unsigned, o_prd = A*B exactly.
REQ-031: Partial sums never exceed 2^PW-1, so the multiplier's carry SHALL be 0 at every pass boundary; the sequencer relies on this and SHALL NOT insert flush cycles.
REQ-032: Operand changes after the transfer edge SHALL have no effect on the job in flight.

Reset
REQ-033: While i_nrst=0, the state SHALL be IDLE, j=k=0, A=B=0, o_prd=0, o_done=0, o_q=0, o_m=0 and o_clr_n=0.
REQ-034: o_ready SHALL be 1 while i_nrst=0.
REQ-035: o_clr_n SHALL go to 1 on the first rising edge after i_nrst deasserts.
REQ-036: Reset asserted mid-job (any state) SHALL abort immediately with no o_done pulse.
REQ-037: The next accepted job after a reset SHALL complete correctly.

Verification
REQ-038: i_a=13, i_b=11, one-cycle i_valid -> o_done pulse 130 cycles after the accept edge, o_prd=0x008F.
REQ-039: i_a=255, i_b=255 -> o_prd=0xFE01; i_a=0, i_b=200 -> 0x0000; i_a=200, i_b=0 -> 0x0000.
REQ-040: i_a=0x81, i_b=0x02, sample o_q/o_m in RUN -> o_q=0 in pass 0 and 1 in pass 1; pass 1 o_m=1 only at k=1 and k=8; o_prd=0x0102.
REQ-041: i_valid held high through a job with operands changed to 3,5 mid-job -> first result unchanged; second job accepted in the o_done cycle gives o_prd=15.
REQ-042: i_nrst pulsed low at RUN cycle 50 of 7*9 -> o_prd=0, o_done never pulses, o_ready=1; re-issue 7*9 -> o_prd=63.
REQ-043: The bench SHALL check that o_clr_n is low for exactly one cycle per job, immediately after each accept edge.
